// File: rtl/two_sorter_if.sv
// two_sorter_if: handshake and data bundle for one compare-and-swap cell.
// The master side presents operand pairs. The slave side (the sorter)
// returns the ordered pair, the swap flag and the swap count.
interface two_sorter_if #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
);
  logic                 in_valid;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic [WIDTH-1:0]     c;
  logic [WIDTH-1:0]     d;
  logic                 swapped;
  logic [CNT_WIDTH-1:0] swap_cnt;

  modport master (
    output in_valid, a, b,
    input  out_valid, c, d, swapped, swap_cnt
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, c, d, swapped, swap_cnt
  );
endinterface

// File: rtl/two_sorter.sv
// two_sorter: registered compare-and-swap cell of the sorting network.
// For each accepted pair, the smaller word goes to c and the larger to d,
// one cycle later, qualified by out_valid. swapped marks pairs with a > b.
// Optional feature macro: TWO_SORTER_SWAP_CNT_EN.
//   Defined:   swap_cnt is a saturating count of swapped pairs.
//   Undefined: no counter logic, and swap_cnt is tied to zero.
// Reset is synchronous and active-high, and it takes priority over in_valid.
module two_sorter #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input logic        clk,
  input logic        rst,
  two_sorter_if.slave bus
);

  logic             a_gt_b;
  logic [WIDTH-1:0] lo_val;
  logic [WIDTH-1:0] hi_val;

  logic             out_valid_q;
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] d_q;
  logic             swapped_q;

  // Unsigned magnitude compare. Equal operands keep their order and are not a swap.
  always_comb begin
    a_gt_b = 1'b0;
    lo_val = bus.a;
    hi_val = bus.b;
    if (bus.a > bus.b) begin
      a_gt_b = 1'b1;
      lo_val = bus.b;
      hi_val = bus.a;
    end
  end

  // Output stage: capture the ordered pair on accept, and hold it while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      c_q         <= '0;
      d_q         <= '0;
      swapped_q   <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        c_q       <= lo_val;
        d_q       <= hi_val;
        swapped_q <= a_gt_b;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign bus.d         = d_q;
  assign bus.swapped   = swapped_q;

`ifdef TWO_SORTER_SWAP_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] swap_cnt_q;
  logic                 cnt_at_max;

  assign cnt_at_max = &swap_cnt_q;

  // Saturating swap counter. It stops at all-ones rather than wrapping to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      swap_cnt_q <= '0;
    end else if (bus.in_valid && a_gt_b && !cnt_at_max) begin
      swap_cnt_q <= swap_cnt_q + CNT_ONE;
    end
  end

  assign bus.swap_cnt = swap_cnt_q;
`else
  assign bus.swap_cnt = '0;
`endif

  // Any valid result must be ordered.
  a_sorted: assert property (@(posedge clk) disable iff (rst)
    bus.out_valid |-> (bus.c <= bus.d));

  // A reset edge always clears the valid qualifier.
  a_reset_clears_valid: assert property (@(posedge clk)
    rst |=> !bus.out_valid);

endmodule

// File: tb/tb_two_sorter.sv
// tb_two_sorter: drives three sorter instances in lockstep.
//   - 4-bit data with an 8-bit counter
//   - 16-bit data with an 8-bit counter
//   - 4-bit data with a 2-bit counter, to exercise saturation
// A behavioural model (min/max and a saturating count) predicts every output.
module tb_two_sorter;

  localparam bit CNT_EN =
`ifdef TWO_SORTER_SWAP_CNT_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  two_sorter_if #(.WIDTH(4),  .CNT_WIDTH(8)) bus4 ();
  two_sorter_if #(.WIDTH(16), .CNT_WIDTH(8)) bus16 ();
  two_sorter_if #(.WIDTH(4),  .CNT_WIDTH(2)) bus_sat ();

  two_sorter #(.WIDTH(4),  .CNT_WIDTH(8)) u_w4  (.clk(clk), .rst(rst), .bus(bus4.slave));
  two_sorter #(.WIDTH(16), .CNT_WIDTH(8)) u_w16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  two_sorter #(.WIDTH(4),  .CNT_WIDTH(2)) u_sat (.clk(clk), .rst(rst), .bus(bus_sat.slave));

  int n_tests = 0;
  int n_fail  = 0;

  // Model state per instance: 0 = w4, 1 = w16, 2 = sat.
  int m_v[3], m_c[3], m_d[3], m_s[3], m_cnt[3], m_a[3], m_b[3];
  int cnt_max[3] = '{255, 255, 3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_update(input int k, input bit r, input bit v, input int x, input int y);
    if (r) begin
      m_v[k] = 0; m_c[k] = 0; m_d[k] = 0; m_s[k] = 0; m_cnt[k] = 0;
    end else begin
      m_v[k] = v;
      if (v) begin
        m_c[k] = (x < y) ? x : y;
        m_d[k] = (x < y) ? y : x;
        m_s[k] = (x > y) ? 1 : 0;
        if (x > y && m_cnt[k] < cnt_max[k]) m_cnt[k]++;
        m_a[k] = x;
        m_b[k] = y;
      end
    end
  endtask

  task automatic check_inst(input int k, input string name, input logic ov,
                            input logic [31:0] c, input logic [31:0] d,
                            input logic s, input logic [31:0] cnt);
    check({name, ".out_valid"}, {31'd0, ov}, m_v[k]);
    check({name, ".c"}, c, m_c[k]);
    check({name, ".d"}, d, m_d[k]);
    check({name, ".swapped"}, {31'd0, s}, m_s[k]);
    check({name, ".swap_cnt"}, cnt, CNT_EN ? m_cnt[k] : 0);
    if (m_v[k] != 0) begin
      check({name, ".ordered"}, {31'd0, c <= d}, 1);
      check({name, ".perm"},
            {31'd0, ((c == m_a[k]) && (d == m_b[k])) || ((c == m_b[k]) && (d == m_a[k]))}, 1);
    end
  endtask

  // One clock: drive inputs, step the model, then sample just after the edge.
  task automatic step(input bit r, input bit v, input int a4, input int b4,
                      input int a16, input int b16);
    rst = r;
    bus4.in_valid    = v; bus4.a    = 4'(a4);   bus4.b    = 4'(b4);
    bus_sat.in_valid = v; bus_sat.a = 4'(a4);   bus_sat.b = 4'(b4);
    bus16.in_valid   = v; bus16.a   = 16'(a16); bus16.b   = 16'(b16);
    @(posedge clk);
    #1;
    model_update(0, r, v, a4, b4);
    model_update(1, r, v, a16, b16);
    model_update(2, r, v, a4, b4);
    check_inst(0, "w4",  bus4.out_valid,    32'(bus4.c),    32'(bus4.d),    bus4.swapped,    32'(bus4.swap_cnt));
    check_inst(1, "w16", bus16.out_valid,   32'(bus16.c),   32'(bus16.d),   bus16.swapped,   32'(bus16.swap_cnt));
    check_inst(2, "sat", bus_sat.out_valid, 32'(bus_sat.c), 32'(bus_sat.d), bus_sat.swapped, 32'(bus_sat.swap_cnt));
  endtask

  int dir_a[9] = '{3, 2, 6, 15, 8, 0, 15, 0, 15};
  int dir_b[9] = '{2, 3, 6, 3, 11, 15, 0, 0, 15};
  int exp_c[9] = '{2, 2, 6, 3, 8, 0, 0, 0, 15};
  int exp_d[9] = '{3, 3, 6, 15, 11, 15, 15, 0, 15};
  int exp_s[9] = '{1, 0, 0, 1, 0, 0, 1, 0, 0};
  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    rst = 1'b1;
    bus4.in_valid = 1'b0;    bus4.a = '0;    bus4.b = '0;
    bus16.in_valid = 1'b0;   bus16.a = '0;   bus16.b = '0;
    bus_sat.in_valid = 1'b0; bus_sat.a = '0; bus_sat.b = '0;

    // Reset with a pair presented: the pair must be discarded.
    step(1, 1, 9, 2, 9, 2);
    step(1, 0, 0, 0, 0, 0);
    check("reset.out_valid", {31'd0, bus4.out_valid}, 0);

    // Directed pairs followed by the boundary values.
    for (int i = 0; i < 9; i++) begin
      step(0, 1, dir_a[i], dir_b[i], dir_a[i], dir_b[i]);
      check("dir.c", 32'(bus4.c), exp_c[i]);
      check("dir.d", 32'(bus4.d), exp_d[i]);
      check("dir.s", {31'd0, bus4.swapped}, exp_s[i]);
      check("dir.out_valid", {31'd0, bus4.out_valid}, 1);
      if (i == 4) check("dir.swap_cnt", 32'(bus4.swap_cnt), CNT_EN ? 2 : 0);
    end

    // Gap: the result holds while idle, and out_valid drops.
    step(0, 1, 9, 4, 9, 4);
    check("gap.valid0", {31'd0, bus4.out_valid}, 1);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 1, 0, 1, 0);
      check("gap.c", 32'(bus4.c), 4);
      check("gap.d", 32'(bus4.d), 9);
      check("gap.valid", {31'd0, bus4.out_valid}, 0);
      check("gap.swap_cnt", 32'(bus4.swap_cnt), CNT_EN ? 4 : 0);
    end

    // Reset mid-stream.
    step(1, 1, 7, 1, 7, 1);
    check("mid_rst.c", 32'(bus4.c), 0);
    check("mid_rst.cnt", 32'(bus4.swap_cnt), 0);
    step(0, 1, 7, 1, 7, 1);
    check("after_rst.c", 32'(bus4.c), 1);
    check("after_rst.d", 32'(bus4.d), 7);
    check("after_rst.s", {31'd0, bus4.swapped}, 1);
    check("after_rst.cnt", 32'(bus4.swap_cnt), CNT_EN ? 1 : 0);

    // Saturation of the 2-bit counter.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 5, 1, 5, 1);
      check("sat.cnt", 32'(bus_sat.swap_cnt), CNT_EN ? sat_exp[i] : 0);
    end

    // Random streaming with occasional gaps and resets.
    for (int i = 0; i < 1000; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/two_sorter.md
# two_sorter

Two-input compare-and-swap element, the basic cell of the sorting-network datapath. Each accepted pair of unsigned words is presented on the outputs in ascending order: smaller value on `c`, larger on `d`. A swap flag and an optional saturating swap counter are provided. Outputs are registered, one pipeline stage, with a valid qualifier.

## Interface
Parameters:
- `WIDTH`, default 4: bit width of each data word (≥1).
- `CNT_WIDTH`, default 8: width of the swap counter (≥1).

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: reset, synchronous, active-high.
- `in_valid`  input  1: `a`/`b` carry a pair to sort this cycle.
- `a`  input  WIDTH: first operand, unsigned.
- `b`  input  WIDTH: second operand, unsigned.
- `out_valid`  output  1: `c`/`d`/`swapped` hold a sorted result.
- `c`  output  WIDTH: min(a, b).
- `d`  output  WIDTH: max(a, b).
- `swapped`  output  1: 1 when the operands were exchanged (a > b).
- `swap_cnt`  output  CNT_WIDTH: saturating count of swapped pairs.

## Operation
- Compare is unsigned magnitude over full WIDTH.
- a > b: c = b, d = a, swapped = 1.
- a ≤ b: c = a, d = b, swapped = 0. Equal operands never count as a swap.
- Invariant on every cycle with out_valid = 1: c ≤ d, and {c, d} is a permutation of the accepted {a, b}.
- in_valid = 0: c, d and swapped hold their last values; out_valid drops to 0 on the next edge.
- No backpressure. Every cycle with in_valid = 1 is accepted, so full-rate streaming is supported.
- swap_cnt increments by 1 on each accepted pair with a > b. It saturates at all-ones and does not wrap.

## Timing
- Latency 1 cycle. A pair sampled at edge N appears on c/d/swapped with out_valid = 1 after edge N, and stays until edge N+1.
- Throughput: one pair per cycle.
- Reset values (rst = 1 at an edge): out_valid = 0, c = 0, d = 0, swapped = 0, swap_cnt = 0.
- rst has priority over in_valid. A pair presented in a reset cycle is discarded and not counted.
- Reset mid-stream: after the first edge with rst = 0, the next valid pair behaves as the first result after reset.
- No combinational path from inputs to outputs.

## Configuration
- `TWO_SORTER_SWAP_CNT_EN`
  - Defined: the saturating swap counter is implemented as described.
  - Undefined: no counter logic; swap_cnt is driven constant 0.
  - The sorting, swapped flag, valid and latency behaviour is identical in both builds.

## Test plan
- Reset, then pairs (3,2), (2,3), (6,6), (15,3), (8,11) on consecutive cycles with in_valid = 1. Required outputs one cycle later each:
  - (2,3) with swapped = 1
  - (2,3) with swapped = 0
  - (6,6) with swapped = 0
  - (3,15) with swapped = 1
  - (8,11) with swapped = 0
  - swap_cnt ends at 2 (counter build).
- Boundary values (0,15), (15,0), (0,0), (15,15) -> (0,15,s=0), (0,15,s=1), (0,0,s=0), (15,15,s=0). out_valid = 1 each cycle.
- in_valid gap: pair (9,4), then two idle cycles -> c = 4, d = 9 held; out_valid = 1 for one cycle then 0; swap_cnt unchanged during the idle cycles.
- Reset mid-stream: assert rst while presenting (7,1) -> next cycle out_valid = 0, c = d = 0, swap_cnt = 0. Release, present (7,1) -> (1,7, s=1), swap_cnt = 1.
- Saturation: CNT_WIDTH = 2, five swapped pairs (5,1) -> swap_cnt reads 1, 2, 3, 3, 3. Built without the macro -> swap_cnt = 0 throughout.
- Random 1000 pairs, WIDTH = 4 and WIDTH = 16 -> c ≤ d and {c, d} = {a, b} one cycle later on every out_valid cycle.
